// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with 50 % duty (even and odd D) and pulse
// output modes. Divisor, mode and enable changes take effect only at period boundaries.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             div_load,
    input  logic             mode,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] div_active,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] DIV_DEF = WIDTH'(DIV_DEFAULT);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             mode_q, mode_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic             clk_p_q, clk_p_d;
    logic             err_q, err_d;
    logic             clk_n_q;
    logic             gate_q;
    logic             boundary_s;
    logic             load_ok_s;

    // Next-state logic: boundary handling, pending divisor and output phase
    always_comb begin
        load_ok_s  = div_load && (div != ZERO);
        boundary_s = !run_q || (cnt_q == (div_act_q - ONE));
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        mode_d     = mode_q;
        run_d      = run_q;
        tick_d     = 1'b0;
        err_d      = div_load && (div == ZERO);
        if (boundary_s) begin
            // A load coincident with the boundary beats the pending value.
            if (load_ok_s) begin
                div_act_d = div;
            end else if (pend_vld_q) begin
                div_act_d = pend_q;
            end else begin
                div_act_d = div_act_q;
            end
            pend_vld_d = 1'b0;
            mode_d     = mode;
            run_d      = en;
            if (en) begin
                cnt_d  = ZERO;
                tick_d = 1'b1;
            end else begin
                cnt_d  = div_act_d - ONE;
            end
        end else begin
            cnt_d = cnt_q + ONE;
            if (load_ok_s) begin
                pend_d     = div;
                pend_vld_d = 1'b1;
            end else begin
                pend_d     = pend_q;
                pend_vld_d = pend_vld_q;
            end
        end
        // D=1 is produced by gating clk directly, so clk_p stays idle there.
        if (!run_d || (div_act_d == ONE)) begin
            clk_p_d = 1'b0;
        end else if (mode_d) begin
            clk_p_d = (cnt_d == ZERO);
        end else begin
            clk_p_d = (cnt_d < (div_act_d >> 1));
        end
    end

    // Posedge state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= DIV_DEF - ONE;
            div_act_q  <= DIV_DEF;
            pend_q     <= ZERO;
            pend_vld_q <= 1'b0;
            mode_q     <= 1'b0;
            run_q      <= 1'b0;
            tick_q     <= 1'b0;
            clk_p_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            mode_q     <= mode_d;
            run_q      <= run_d;
            tick_q     <= tick_d;
            clk_p_q    <= clk_p_d;
            err_q      <= err_d;
        end
    end

    // Negedge copies: half-cycle extension for odd D and the D=1 clock gate
    always_ff @(negedge clk) begin
        clk_n_q <= clk_p_q;
        gate_q  <= run_q;
    end

    // Output clock selection by active divisor and latched mode
    always_comb begin
        if (div_act_q == ONE) begin
            clk_out = clk & gate_q;
        end else if (!mode_q && div_act_q[0]) begin
            clk_out = clk_p_q | clk_n_q;
        end else begin
            clk_out = clk_p_q;
        end
    end

    assign tick       = tick_q;
    assign running    = run_q;
    assign div_active = div_act_q;
    assign div_err    = err_q;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock divider. Divides clk by an integer D loaded at run time, with two output modes: 50 % duty for both even and odd D, or a single-cycle pulse.
- Divisor, mode and enable changes are applied only at output-period boundaries, so clk_out never produces a runt pulse.
- Drives slow peripheral clocks and sample strobes in the sensor/temperature subsystem. Replaces fixed-ratio dividers.

Parameters:
- WIDTH, 8, width of the divisor bus and internal counters.
- DIV_DEFAULT, 5, active divisor after reset. Must be >= 1.

Ports:
- clk  in  1  input clock.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- en  in  1  run request. Sampled only at period boundaries.
- div  in  WIDTH  requested divisor D.
- div_load  in  1  one-cycle strobe; captures div into the pending register.
- mode  in  1  0 = 50 % duty, 1 = pulse. Sampled at period boundaries.
- clk_out  out  1  divided clock.
- tick  out  1  one-clk-cycle strobe, high on the first input cycle of each output period.
- running  out  1  high while the divider is producing periods.
- div_active  out  WIDTH  divisor currently in use.
- div_err  out  1  one-cycle pulse when a load of div=0 is rejected.

Behaviour:
- Reset (rst_n=0 at posedge), all synchronous:
  - cnt = div_active - 1; div_active = DIV_DEFAULT; pending invalid.
  - clk_p = 0, clk_n = 0 (clk_n clears at the next negedge).
  - clk_out = 0, tick = 0, running = 0, div_err = 0.
  - Reset mid-period truncates the period immediately; a short high phase is permitted only on that edge.
- Period boundary: a posedge where running=0, or where cnt == div_active-1. At a boundary, in this order:
  1. If pending is valid, or div_load=1 with div != 0 in the same cycle, load div_active. The coincident load wins and takes effect for the period starting now. Clear pending.
  2. Latch mode.
  3. running <= en.
  4. If the new running=1: cnt <= 0 and tick <= 1. Otherwise cnt <= div_active-1.
- Non-boundary posedge while running: cnt <= cnt+1, tick <= 0.
- Loads:
  - div_load with div != 0 sets pending = div. The last load before a boundary wins.
  - div_load with div = 0 is ignored; div_err is pulsed for 1 cycle and pending is unchanged.
- 50 % duty mode, D = div_active >= 2:
  - clk_p is a posedge flop equal to (new cnt < D>>1) while running, else 0.
  - clk_n is a negedge flop copy of clk_p.
  - Even D: clk_out = clk_p. High D/2 cycles, low D/2 cycles.
  - Odd D: clk_out = clk_p | clk_n. High (D-1)/2 + 0.5 cycles, low the remainder.
- Pulse mode, D >= 2: clk_p = (new cnt == 0); clk_out = clk_p. High exactly 1 input cycle per period.
- D = 1, either mode:
  - clk_out = clk & gate, where gate is running captured on negedge clk. This makes clk_out glitch-free.
  - tick = 1 every cycle while running.
- Timing:
  - The first clk_out rising edge is the posedge on which tick rises: 1 clk after the first boundary with en=1.
  - en deassert completes the current period. running falls at the next boundary and clk_out stays low afterwards.
- Counters: cnt is WIDTH bits and never exceeds div_active-1. No overflow is possible since D <= 2^WIDTH-1.

Test Plan:
- Reset, en=1, no load → div_active=5, first tick 1 cycle after reset release. clk_out high 2.5 / low 2.5 cycles, period 5 cycles, tick every 5 cycles.
- Load div=4 while idle, then en=1 → clk_out high 2 / low 2 cycles. tick pulses are 4 cycles apart and coincide with clk_out rising edges.
- Running D=5; load div=8 at cnt=1, then load div=6 at cnt=3 → the current period completes at 5 cycles, next period is 6 cycles (last load wins), div_active=6 from that boundary.
- Load div=0 → div_err high exactly 1 cycle, div_active and pending unchanged, output period unchanged.
- mode=1, D=3, en dropped at cnt=1 → 1-cycle pulses every 3 cycles. The current period finishes, running falls at the boundary, clk_out stays 0.
- D=1, en=1 → clk_out toggles with clk, tick constantly 1. Assert rst_n=0 mid-stream → all outputs 0 at the next posedge, with no clk_out pulse shorter than half a clk period.
